// File: rtl/usb_xact_pkg.sv
// Shared USB definitions for the EP0 transaction sequencer: PID encodings,
// standard request codes and the transaction state enum.
package usb_xact_pkg;

    typedef enum logic [3:0] {
        PidOut   = 4'b0001,
        PidIn    = 4'b1001,
        PidSetup = 4'b1101,
        PidData0 = 4'b0011,
        PidData1 = 4'b1011,
        PidAck   = 4'b0010,
        PidNak   = 4'b1010,
        PidStall = 4'b1110
    } pid_t;

    localparam logic [7:0] REQ_TYPE_STD_OUT = 8'h00;
    localparam logic [7:0] REQ_SET_ADDRESS  = 8'h05;

    typedef enum logic [1:0] {
        StIdle,
        StWaitData,
        StSend,
        StWaitHs
    } xact_state_e;

    function automatic logic is_data_pid(logic [3:0] pid);
        return (pid == PidData0) || (pid == PidData1);
    endfunction

endpackage

// File: rtl/usb_xact_timer.sv
// Turnaround timeout counter: held at zero by load, counts while enabled and
// flags expiry once it reaches TIMEOUT_CYCLES.
module usb_xact_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 96,
    parameter int unsigned TOW            = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [TOW-1:0] Limit = TOW'(TIMEOUT_CYCLES);

    logic [TOW-1:0] cnt_q;

    assign expire = en & (cnt_q == Limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr | load) begin
            cnt_q <= '0;
        end else if (en & ~expire) begin
            cnt_q <= cnt_q + TOW'(1);
        end
    end

endmodule

// File: rtl/usb_xact_ctrl.sv
// EP0 device-side transaction sequencer: token response, data toggles,
// turnaround timeout and deferred SET_ADDRESS. Optional USB_XACT_STATS_EN adds error/timeout counters.
module usb_xact_ctrl
    import usb_xact_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 96,
    parameter int unsigned TOW            = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        usb_rst,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic [3:0]  rx_len,
    output logic        tx_req,
    output logic [3:0]  tx_pid,
    output logic [63:0] tx_data,
    output logic [3:0]  tx_len,
    input  logic        tx_done,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic [3:0]  in_len,
    output logic        in_taken,
    output logic        out_valid,
    output logic        setup_valid,
    output logic [63:0] app_data,
    input  logic        ep_stall,
    output logic [6:0]  dev_addr
`ifdef USB_XACT_STATS_EN
    ,
    output logic [15:0] err_cnt,
    output logic [15:0] tmo_cnt
`endif
);

    xact_state_e state_q, state_d;
    logic        setup_br_q, setup_br_d;
    logic        rx_tog_q, rx_tog_d, tx_tog_q, tx_tog_d;
    logic [6:0]  dev_addr_q, dev_addr_d, pend_addr_q, pend_addr_d;
    logic        pend_vld_q, pend_vld_d;
    logic        tx_req_q, tx_req_d, tx_is_data_q, tx_is_data_d;
    logic [3:0]  tx_pid_q, tx_pid_d, tx_len_q, tx_len_d;
    logic [63:0] tx_data_q, tx_data_d, app_data_q, app_data_d;
    logic        setup_valid_q, setup_valid_d, out_valid_q, out_valid_d;
    logic        in_taken_q, in_taken_d;

    logic        pkt_ok, tok_ok, in_wait, tmo_expire;
    logic        send_en, send_is_data;
    pid_t        send_pid;
    logic [63:0] send_data;
    logic [3:0]  send_len;
    logic        unused_rx_len;

    assign unused_rx_len = ^rx_len;

    // Data/handshake packets carry no address; only tokens are address-matched.
    assign pkt_ok  = rx_valid & ~rx_error;
    assign tok_ok  = pkt_ok & (rx_addr == dev_addr_q);
    assign in_wait = (state_q == StWaitData) | (state_q == StWaitHs);

    usb_xact_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TOW           (TOW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (usb_rst),
        .load  (~in_wait),
        .en    (in_wait),
        .expire(tmo_expire)
    );

    always_comb begin
        state_d       = state_q;
        setup_br_d    = setup_br_q;
        rx_tog_d      = rx_tog_q;
        tx_tog_d      = tx_tog_q;
        dev_addr_d    = dev_addr_q;
        pend_addr_d   = pend_addr_q;
        pend_vld_d    = pend_vld_q;
        tx_req_d      = tx_req_q;
        tx_is_data_d  = tx_is_data_q;
        tx_pid_d      = tx_pid_q;
        tx_len_d      = tx_len_q;
        tx_data_d     = tx_data_q;
        app_data_d    = app_data_q;
        setup_valid_d = 1'b0;
        out_valid_d   = 1'b0;
        in_taken_d    = 1'b0;
        send_en       = 1'b0;
        send_pid      = PidNak;
        send_data     = '0;
        send_len      = '0;
        send_is_data  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tok_ok && (rx_pid == PidSetup || rx_pid == PidOut || rx_pid == PidIn)) begin
                    if (rx_endp != 4'd0) begin
                        send_en  = 1'b1;
                        send_pid = PidStall;
                    end else if (rx_pid == PidIn) begin
                        send_en = 1'b1;
                        if (ep_stall) begin
                            send_pid = PidStall;
                        end else if (!in_valid) begin
                            send_pid = PidNak;
                        end else begin
                            send_pid     = tx_tog_q ? PidData1 : PidData0;
                            send_data    = in_data;
                            send_len     = in_len;
                            send_is_data = 1'b1;
                        end
                    end else begin
                        state_d    = StWaitData;
                        setup_br_d = (rx_pid == PidSetup);
                        if (rx_pid == PidSetup) begin
                            rx_tog_d   = 1'b0;
                            tx_tog_d   = 1'b1;
                            pend_vld_d = 1'b0;
                        end
                    end
                end
            end
            StWaitData: begin
                if (pkt_ok) begin
                    if (is_data_pid(rx_pid)) begin
                        send_en  = 1'b1;
                        send_pid = PidAck;
                        if (setup_br_q) begin
                            setup_valid_d = 1'b1;
                            app_data_d    = rx_data;
                            rx_tog_d      = 1'b1;
                            pend_vld_d    = (rx_data[15:0] == {REQ_SET_ADDRESS, REQ_TYPE_STD_OUT});
                            pend_addr_d   = rx_data[22:16];
                        end else if (ep_stall) begin
                            send_pid = PidStall;
                        end else if ((rx_pid == PidData1) == rx_tog_q) begin
                            out_valid_d = 1'b1;
                            app_data_d  = rx_data;
                            rx_tog_d    = ~rx_tog_q;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmo_expire) begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (tx_done) begin
                    tx_req_d = 1'b0;
                    state_d  = tx_is_data_q ? StWaitHs : StIdle;
                end
            end
            StWaitHs: begin
                if (pkt_ok) begin
                    state_d = StIdle;
                    if (rx_pid == PidAck) begin
                        tx_tog_d   = ~tx_tog_q;
                        in_taken_d = 1'b1;
                        if (pend_vld_q) begin
                            dev_addr_d = pend_addr_q;
                            pend_vld_d = 1'b0;
                        end
                    end
                end else if (tmo_expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (send_en) begin
            state_d      = StSend;
            tx_req_d     = 1'b1;
            tx_pid_d     = send_pid;
            tx_data_d    = send_data;
            tx_len_d     = send_len;
            tx_is_data_d = send_is_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || usb_rst) begin
            state_q       <= StIdle;
            setup_br_q    <= 1'b0;
            rx_tog_q      <= 1'b0;
            tx_tog_q      <= 1'b1;
            dev_addr_q    <= '0;
            pend_addr_q   <= '0;
            pend_vld_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            tx_is_data_q  <= 1'b0;
            tx_pid_q      <= '0;
            tx_len_q      <= '0;
            tx_data_q     <= '0;
            app_data_q    <= '0;
            setup_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_taken_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            setup_br_q    <= setup_br_d;
            rx_tog_q      <= rx_tog_d;
            tx_tog_q      <= tx_tog_d;
            dev_addr_q    <= dev_addr_d;
            pend_addr_q   <= pend_addr_d;
            pend_vld_q    <= pend_vld_d;
            tx_req_q      <= tx_req_d;
            tx_is_data_q  <= tx_is_data_d;
            tx_pid_q      <= tx_pid_d;
            tx_len_q      <= tx_len_d;
            tx_data_q     <= tx_data_d;
            app_data_q    <= app_data_d;
            setup_valid_q <= setup_valid_d;
            out_valid_q   <= out_valid_d;
            in_taken_q    <= in_taken_d;
        end
    end

    // Bus reset must abort a transmission in progress without waiting for an edge.
    assign tx_req      = tx_req_q & ~usb_rst;
    assign tx_pid      = tx_pid_q;
    assign tx_data     = tx_data_q;
    assign tx_len      = tx_len_q;
    assign in_taken    = in_taken_q;
    assign out_valid   = out_valid_q;
    assign setup_valid = setup_valid_q;
    assign app_data    = app_data_q;
    assign dev_addr    = dev_addr_q;

`ifdef USB_XACT_STATS_EN
    logic [15:0] err_cnt_q, tmo_cnt_q;
    logic        tmo_evt;

    assign tmo_evt = tmo_expire & ~pkt_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else if (usb_rst) begin
            err_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (rx_valid && rx_error && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (tmo_evt && tmo_cnt_q != 16'hFFFF) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt = err_cnt_q;
    assign tmo_cnt = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_usb_xact_ctrl.sv
// Directed, table-driven bench for usb_xact_ctrl (default build, stats disabled).
module tb_usb_xact_ctrl;
    import usb_xact_pkg::*;

    localparam int unsigned TMO = 96;

    logic        clk, rst_n, usb_rst;
    logic        rx_valid, rx_error;
    logic [3:0]  rx_pid, rx_endp, rx_len;
    logic [6:0]  rx_addr;
    logic [63:0] rx_data;
    logic        tx_req, tx_done;
    logic [3:0]  tx_pid, tx_len;
    logic [63:0] tx_data;
    logic        in_valid, in_taken, out_valid, setup_valid, ep_stall;
    logic [63:0] in_data, app_data;
    logic [3:0]  in_len;
    logic [6:0]  dev_addr;

    int total = 0;
    int bad   = 0;

    usb_xact_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .TOW           (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .usb_rst    (usb_rst),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_pid     (rx_pid),
        .rx_addr    (rx_addr),
        .rx_endp    (rx_endp),
        .rx_data    (rx_data),
        .rx_len     (rx_len),
        .tx_req     (tx_req),
        .tx_pid     (tx_pid),
        .tx_data    (tx_data),
        .tx_len     (tx_len),
        .tx_done    (tx_done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_taken   (in_taken),
        .out_valid  (out_valid),
        .setup_valid(setup_valid),
        .app_data   (app_data),
        .ep_stall   (ep_stall),
        .dev_addr   (dev_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        err;
        logic        stall;
        logic        ivld;
        logic [3:0]  ilen;
        logic [63:0] idata;
        logic        exp_req;
        logic [3:0]  exp_pid;
        logic [3:0]  exp_len;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                            input logic [63:0] data, input logic err);
        rx_valid = 1'b1;
        rx_error = err;
        rx_pid   = pid;
        rx_addr  = addr;
        rx_endp  = endp;
        rx_data  = data;
        rx_len   = 4'd8;
        tick();
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [3:0] pid, input logic [3:0] len,
                             input logic [63:0] data);
        int n = 0;
        while (!tx_req && n < 8) begin
            tick();
            n++;
        end
        chk({name, "_req"}, tx_req, 1'b1);
        chk({name, "_pid"}, tx_pid, pid);
        if (pid == PidData0 || pid == PidData1) begin
            chk({name, "_len"}, tx_len, len);
            chk({name, "_data"}, tx_data, data);
        end
        tick();
        chk({name, "_hold"}, {tx_req, tx_pid}, {1'b1, pid});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({name, "_drop"}, tx_req, 1'b0);
    endtask

    task automatic expect_none(input string name);
        tick();
        tick();
        chk({name, "_noreq"}, tx_req, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; usb_rst = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_pid = '0;
        rx_addr = '0; rx_endp = '0; rx_data = '0; rx_len = '0; tx_done = 1'b0;
        in_valid = 1'b0; in_data = '0; in_len = '0; ep_stall = 1'b0;

        vecs[0] = '{PidIn,    7'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, PidNak,   4'd0};
        vecs[1] = '{PidIn,    7'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 64'h55, 1'b1, PidStall, 4'd0};
        vecs[2] = '{PidIn,    7'd5, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 64'h55, 1'b0, PidNak,   4'd0};
        vecs[3] = '{PidOut,   7'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, PidStall, 4'd0};
        vecs[4] = '{PidSetup, 7'd0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, PidStall, 4'd0};
        vecs[5] = '{PidIn,    7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 64'h4433_2211, 1'b1, PidData1, 4'd4};
        vecs[6] = '{PidIn,    7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 64'hBEEF, 1'b1, PidData1, 4'd2};
        vecs[7] = '{PidIn,    7'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 64'hBEEF, 1'b0, PidNak,   4'd0};

        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_tx_pid", tx_pid, 4'd0);
        chk("rst_tx_len", tx_len, 4'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_dev_addr", dev_addr, 7'd0);
        chk("rst_pulses", {in_taken, out_valid, setup_valid}, 3'b000);

        // OUT toggle handling: DATA0 accepted, repeated DATA0 ACKed but dropped
        send_pkt(PidOut, 7'd0, 4'd0, 64'd0, 1'b0);
        send_pkt(PidData0, 7'd0, 4'd0, 64'h0102_0304_0506_0708, 1'b0);
        chk("out1_valid", out_valid, 1'b1);
        chk("out1_data", app_data, 64'h0102_0304_0506_0708);
        expect_tx("out1_ack", PidAck, 4'd0, 64'd0);
        send_pkt(PidOut, 7'd0, 4'd0, 64'd0, 1'b0);
        send_pkt(PidData0, 7'd0, 4'd0, 64'hAAAA, 1'b0);
        chk("out2_novalid", out_valid, 1'b0);
        expect_tx("out2_ack", PidAck, 4'd0, 64'd0);

        // Single-token responses from IDLE
        for (int i = 0; i < 8; i++) begin
            ep_stall = vecs[i].stall;
            in_valid = vecs[i].ivld;
            in_len   = vecs[i].ilen;
            in_data  = vecs[i].idata;
            send_pkt(vecs[i].pid, vecs[i].addr, vecs[i].endp, 64'd0, vecs[i].err);
            if (vecs[i].exp_req) begin
                expect_tx($sformatf("vec%0d", i), vecs[i].exp_pid, vecs[i].exp_len,
                          vecs[i].idata);
                if (vecs[i].exp_pid == PidData1) begin
                    send_pkt(PidNak, 7'd0, 4'd0, 64'd0, 1'b0);
                end
            end else begin
                expect_none($sformatf("vec%0d", i));
            end
            ep_stall = 1'b0;
            in_valid = 1'b0;
        end

        // Missing host ACK: timeout, then the same DATA1 on retry
        in_valid = 1'b1; in_len = 4'd4; in_data = 64'hCAFE_F00D;
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        expect_tx("tmo_first", PidData1, 4'd4, 64'hCAFE_F00D);
        repeat (TMO + 4) tick();
        chk("tmo_no_taken", in_taken, 1'b0);
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        expect_tx("tmo_retry", PidData1, 4'd4, 64'hCAFE_F00D);
        send_pkt(PidAck, 7'd0, 4'd0, 64'd0, 1'b0);
        chk("tmo_taken", in_taken, 1'b1);
        in_valid = 1'b0;

        // SET_ADDRESS with deferred commit
        send_pkt(PidSetup, 7'd0, 4'd0, 64'd0, 1'b0);
        send_pkt(PidData0, 7'd0, 4'd0, 64'h0000_0000_002A_0500, 1'b0);
        chk("setup_valid", setup_valid, 1'b1);
        chk("setup_data", app_data, 64'h0000_0000_002A_0500);
        expect_tx("setup_ack", PidAck, 4'd0, 64'd0);
        in_valid = 1'b1; in_len = 4'd0; in_data = 64'd0;
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        expect_tx("status_in", PidData1, 4'd0, 64'd0);
        chk("addr_precommit", dev_addr, 7'd0);
        send_pkt(PidAck, 7'd0, 4'd0, 64'd0, 1'b0);
        chk("status_taken", in_taken, 1'b1);
        chk("addr_commit", dev_addr, 7'h2A);
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        expect_none("old_addr");
        in_len = 4'd3; in_data = 64'h77_6655;
        send_pkt(PidIn, 7'h2A, 4'd0, 64'd0, 1'b0);
        expect_tx("new_addr_in", PidData0, 4'd3, 64'h77_6655);
        send_pkt(PidNak, 7'd0, 4'd0, 64'd0, 1'b0);

        // Errored SETUP is ignored, so the following DATA is too
        send_pkt(PidSetup, 7'h2A, 4'd0, 64'd0, 1'b1);
        send_pkt(PidData0, 7'h2A, 4'd0, 64'h0000_0000_0011_0500, 1'b0);
        chk("err_setup_novalid", setup_valid, 1'b0);
        expect_none("err_setup");
        chk("err_setup_addr", dev_addr, 7'h2A);

        // Bus reset during WAIT_HS
        send_pkt(PidIn, 7'h2A, 4'd0, 64'd0, 1'b0);
        expect_tx("hs_rst_in", PidData0, 4'd3, 64'h77_6655);
        usb_rst = 1'b1;
        tick();
        usb_rst = 1'b0;
        chk("usbrst_addr", dev_addr, 7'd0);
        chk("usbrst_req", tx_req, 1'b0);
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        expect_tx("usbrst_tog", PidData1, 4'd3, 64'h77_6655);
        send_pkt(PidNak, 7'd0, 4'd0, 64'd0, 1'b0);

        // Bus reset during SEND drops tx_req without waiting for an edge
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        chk("send_rst_pre", tx_req, 1'b1);
        usb_rst = 1'b1;
        #1;
        chk("send_rst_now", tx_req, 1'b0);
        tick();
        usb_rst = 1'b0;
        tick();
        chk("send_rst_after", tx_req, 1'b0);

        // Asynchronous rst_n between edges
        send_pkt(PidIn, 7'd0, 4'd0, 64'd0, 1'b0);
        chk("arst_pre", tx_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", tx_req, 1'b0);
        chk("arst_pid", tx_pid, 4'd0);
        chk("arst_len", tx_len, 4'd0);
        chk("arst_data", tx_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", tx_req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_xact_ctrl.md
Name: usb_xact_ctrl

Overview:
Device-side transaction sequencer for the hub's control endpoint (EP0).
- Consumes decoded packets from the downstream SIE receiver.
- Decides the response to each token: DATA, ACK, NAK or STALL.
- Tracks data toggles and the turnaround timeout.
- Owns the device address, including deferred SET_ADDRESS commit after the status stage.
- Sits between the SIE receive/transmit paths and the hub application logic.

Parameters:
- TIMEOUT_CYCLES, 96, clk cycles to wait for the follow-on packet (DATA after SETUP/OUT, ACK after sent DATA) before abandoning the transaction.
- TOW, 7, width of the timeout counter (must satisfy 2**TOW > TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- usb_rst  in  1  USB bus reset (SE0 timeout); synchronous clear, same effect as rst_n
- rx_valid  in  1  one-cycle pulse: packet fully received
- rx_error  in  1  qualifies rx_valid: CRC/PID/bitstuff error
- rx_pid  in  4  received PID (pid_t)
- rx_addr  in  7  token address field
- rx_endp  in  4  token endpoint field
- rx_data  in  64  data payload, byte0 = [7:0]
- rx_len  in  4  payload byte count, 0..8
- tx_req  out  1  level: request transmit; held until tx_done
- tx_pid  out  4  PID to send
- tx_data  out  64  payload to send
- tx_len  out  4  payload bytes, 0..8
- tx_done  in  1  one-cycle pulse: transmit finished
- in_valid  in  1  application has EP0 IN data ready
- in_data  in  64  application IN payload
- in_len  in  4  application IN length
- in_taken  out  1  pulse: IN data ACKed by host
- out_valid  out  1  pulse: new OUT data accepted (toggle matched)
- setup_valid  out  1  pulse: new SETUP packet accepted
- app_data  out  64  payload accompanying out_valid/setup_valid
- ep_stall  in  1  application requests STALL on EP0
- dev_addr  out  7  current device address

Behaviour:
Reset (rst_n low, async; or usb_rst high, sync):
- state IDLE, dev_addr = 0, pending address cleared.
- rx toggle = 0, tx toggle = 1.
- tx_req = 0, tx_pid/tx_data/tx_len = 0; all pulses 0.

Token acceptance:
- A token is accepted only when rx_valid & ~rx_error & rx_addr == dev_addr.
- Errored or unmatched packets are ignored silently in every state.

States:
- IDLE
  - SETUP to EP0 → WAIT_DATA (setup); rx toggle forced to 0, tx toggle forced to 1.
  - OUT to EP0 → WAIT_DATA (out).
  - IN to EP0 → SEND.
    - ep_stall → STALL.
    - else ~in_valid → NAK.
    - else DATA0/DATA1 per tx toggle with in_data/in_len.
  - Token to endp != 0 → SEND STALL.
- WAIT_DATA
  - DATA0/1 received → SEND ACK.
  - SETUP branch: always accepted; setup_valid pulses the cycle after rx_valid.
  - OUT branch:
    - ep_stall → STALL, no ACK.
    - toggle matches → out_valid pulse, toggle flips.
    - toggle mismatch → ACK, data discarded, no pulse.
  - Non-DATA PID or timeout → IDLE, nothing sent.
- SEND
  - tx_req asserted the cycle after entry; tx_* stable while tx_req high.
  - On tx_done: DATA sent → WAIT_HS; handshake sent → IDLE.
- WAIT_HS
  - ACK → tx toggle flips, in_taken pulses, pending address commits → IDLE.
  - Timeout or any other packet → IDLE, toggle unchanged (host retries).

SET_ADDRESS:
- Detected on an accepted SETUP with rx_data[7:0]=0x00 and [15:8]=0x05.
- Latches pending = rx_data[22:16].
- Commits on the ACK of the next status-stage IN; dev_addr changes the cycle after that ACK.
- A new SETUP before commit discards the pending address.

Timeout counter:
- Cleared on entry to WAIT_DATA/WAIT_HS.
- Increments each clk; expires when it reaches TIMEOUT_CYCLES.

Boundary and simultaneous events:
- rx_valid in the same cycle as timeout expiry: rx_valid wins.
- usb_rst mid-SEND drops tx_req immediately.

Optional Feature:
USB_XACT_STATS_EN.
- Defined: adds outputs err_cnt[15:0] (rx_error pulses) and tmo_cnt[15:0] (timeouts).
  - Both saturate at 0xFFFF.
  - Cleared by rst_n/usb_rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared USB package: pid_t encodings (OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110), request constants (REQ_SET_ADDRESS=8'h05), the xact state enum.
- One sub-module: usb_xact_timer (load/enable/expire counter, parameterised TIMEOUT_CYCLES).

Test Plan:
- SETUP addr0/EP0 + DATA0 {00 05 2A 00 00 00 00 00}
  - → ACK sent, setup_valid pulse.
  - Status IN → zero-length DATA1; host ACK → dev_addr=0x2A next cycle.
- OUT DATA0 then repeated DATA0 (toggle mismatch) → both ACKed, out_valid pulses once.
- IN with in_valid=0 → NAK; in_valid=1, in_len=4 → DATA1 4 bytes; no host ACK for TIMEOUT_CYCLES → IDLE, same DATA1 resent on retry.
- Token addr 0x05 while dev_addr=0 → no tx_req; token to EP3 → STALL.
- rx_error with SETUP, and usb_rst asserted mid-WAIT_HS → ignored / dev_addr=0, state IDLE, tx_req=0.
- rst_n pulsed asynchronously between clk edges → all outputs zero immediately.
